// File: rtl/spi_master_engine.sv
// SPI mode-0 master byte engine: one byte per handshake, optional slave-select hold
// between bytes, and a programmable SS-high gap between frames.
module spi_master_engine #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 4
) (
    input  logic       SBCLKi,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       HOLD_SS,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       BUSY,
    output logic       SCK,
    output logic       SS,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] LP_DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] LP_GAP_M1 = 8'(SS_GAP - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [6:0]  r_tx_shift;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_sck;
    logic        r_ss;
    logic        r_mosi;
    logic [7:0]  r_phase;
    logic [3:0]  r_half_cnt;
    logic [7:0]  r_gap_cnt;

    logic        w_tx_ready;
    logic        w_busy;
    logic        w_accept;
    logic        w_toggle;
    logic        w_last;

    assign w_accept = TX_VALID && w_tx_ready;
    assign w_toggle = (r_state == S_SHIFT) && (r_phase == LP_DIV_M1);
    assign w_last   = w_toggle && (r_half_cnt == 4'd15);

    always_ff @(posedge SBCLKi or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = HOLD_SS ? S_HOLD : S_GAP;
                end
            end
            S_HOLD: begin
                // A pending byte wins over a released HOLD_SS so SS never blips high.
                if (TX_VALID) begin
                    w_state_next = S_SHIFT;
                end else if (!HOLD_SS) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == LP_GAP_M1) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_ready = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx_ready = 1'b1;
                w_busy     = 1'b0;
            end
            S_HOLD:  w_tx_ready = 1'b1;
            default: w_tx_ready = 1'b0;
        endcase
    end

    always_ff @(posedge SBCLKi or posedge RST) begin
        if (RST) begin
            r_tx_shift <= 7'd0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_phase    <= 8'd0;
            r_half_cnt <= 4'd0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_tx_shift <= TX_DATA[6:0];
                r_mosi     <= TX_DATA[7];
                r_sck      <= 1'b0;
                r_phase    <= 8'd0;
                r_half_cnt <= 4'd0;
            end else if (r_state == S_SHIFT) begin
                if (w_toggle) begin
                    r_phase    <= 8'd0;
                    r_half_cnt <= r_half_cnt + 4'd1;
                    r_sck      <= ~r_sck;
                    if (!r_sck) begin
                        r_rx_shift <= {r_rx_shift[6:0], MISO};
                    end else if (!w_last) begin
                        r_mosi     <= r_tx_shift[6];
                        r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                    end
                    if (w_last) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end
                end else begin
                    r_phase <= r_phase + 8'd1;
                end
            end
        end
    end

    // SS releases one cycle after the final SCK fall, giving the slave hold time on the last bit.
    always_ff @(posedge SBCLKi or posedge RST) begin
        if (RST) begin
            r_ss      <= 1'b1;
            r_gap_cnt <= 8'd0;
        end else begin
            r_ss      <= (r_state == S_GAP) || ((r_state == S_IDLE) && !w_accept);
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
        end
    end

    assign TX_READY = w_tx_ready;
    assign BUSY     = w_busy;
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;
    assign SCK      = r_sck;
    assign SS       = r_ss;
    assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: CLK_DIV=4 and CLK_DIV=2 instances, scoreboard on RX_VALID,
// waveform history for SCK/SS/MOSI/TX_READY shape checks.
module tb_spi_master_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0][7:0] tx_data;
    logic [1:0][7:0] rx_data;
    logic [1:0]      tx_valid, tx_ready, hold_ss, rx_valid, busy, sck, ss, mosi, miso;
    logic            slave_en;
    logic [7:0]      slave_byte, slave_sr;
    logic            ss_d = 1'b1, sck_d = 1'b0;

    assign miso = {mosi[1], slave_en ? slave_sr[7] : mosi[0]};

    spi_master_engine #(.CLK_DIV(4), .SS_GAP(4)) u_dut4 (
        .SBCLKi(clk), .RST(rst), .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]),
        .TX_READY(tx_ready[0]), .HOLD_SS(hold_ss[0]), .RX_DATA(rx_data[0]),
        .RX_VALID(rx_valid[0]), .BUSY(busy[0]), .SCK(sck[0]), .SS(ss[0]),
        .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master_engine #(.CLK_DIV(2), .SS_GAP(4)) u_dut2 (
        .SBCLKi(clk), .RST(rst), .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]),
        .TX_READY(tx_ready[1]), .HOLD_SS(hold_ss[1]), .RX_DATA(rx_data[1]),
        .RX_VALID(rx_valid[1]), .BUSY(busy[1]), .SCK(sck[1]), .SS(ss[1]),
        .MOSI(mosi[1]), .MISO(miso[1])
    );

    // Mode-0 slave: load on SS fall, shift out on SCK fall.
    always @(posedge clk) begin
        ss_d  <= ss[0];
        sck_d <= sck[0];
        if (ss_d && !ss[0])
            slave_sr <= slave_byte;
        else if (sck_d && !sck[0])
            slave_sr <= {slave_sr[6:0], 1'b0};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic ss_h [8192];
    logic sck_h[8192];
    logic mosi_h[8192];
    logic rdy_h[8192];
    logic rxv_h[8192];
    always @(negedge clk) begin
        if (cyc < 8192) begin
            ss_h[cyc]   <= ss[0];
            sck_h[cyc]  <= sck[0];
            mosi_h[cyc] <= mosi[0];
            rdy_h[cyc]  <= tx_ready[0];
            rxv_h[cyc]  <= rx_valid[0];
        end
    end

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         edge_n;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rx_valid[i] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("rx_pending_expectations", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rx_instance", i, e.inst);
                        chk("rx_data", rx_data[i], e.data);
                        chk("rx_valid_cycle", cyc, e.edge_n);
                        $display("rx dut%0d data=0x%02h cycle=%0d", i, rx_data[i], cyc);
                    end
                end
            end
        end
    endtask

    // acc = number of the posedge that accepts the byte. RX_VALID is expected in the
    // (1+16*div)-th cycle counting the cycle right after that edge as the first,
    // i.e. the cycle that starts at posedge acc+16*div.
    task automatic send(input int inst, input logic [7:0] d, input logic [7:0] exp_rx,
                        input bit push, input bit keep, output int acc);
        int div;
        div = (inst == 0) ? 4 : 2;
        tx_data[inst]  = d;
        tx_valid[inst] = 1'b1;
        acc = -1;
        for (int t = 0; t < 300; t++) begin
            if (tx_ready[inst] && !rst) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            chk("accept_timeout_tx_ready", {31'd0, tx_ready[inst]}, 1);
            tx_valid[inst] = 1'b0;
            return;
        end
        if (push) sb_q.push_back('{inst, exp_rx, acc + 16 * div});
        $display("tx dut%0d data=0x%02h accept_edge=%0d", inst, d, acc);
        @(posedge clk);
        #1;
        if (!keep) tx_valid[inst] = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (!busy[inst]) break;
        end
        chk("return_to_idle", {31'd0, busy[inst]}, 0);
    endtask

    function automatic int count_hi(input int sel, input int from, input int to);
        int n = 0;
        for (int k = from; k <= to; k++) begin
            case (sel)
                0:       n += (ss_h[k]   === 1'b1) ? 1 : 0;
                1:       n += (mosi_h[k] === 1'b1) ? 1 : 0;
                2:       n += (rdy_h[k]  === 1'b1) ? 1 : 0;
                default: n += (rxv_h[k]  === 1'b1) ? 1 : 0;
            endcase
        end
        return n;
    endfunction

    initial begin
        int a1, a2, rel, mism, rises;
        logic exp_sck;
        rst = 1'b1;
        tx_data = '0;
        tx_valid = '0;
        hold_ss = '0;
        slave_en = 1'b0;
        slave_byte = 8'h00;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_ss", {31'd0, ss[0]}, 1);
        chk("reset_sck", {31'd0, sck[0]}, 0);
        chk("reset_mosi", {31'd0, mosi[0]}, 0);
        chk("reset_rx_data", {24'd0, rx_data[0]}, 0);
        chk("reset_rx_valid", {31'd0, rx_valid[0]}, 0);
        chk("reset_busy", {31'd0, busy[0]}, 0);
        chk("reset_tx_ready", {31'd0, tx_ready[0]}, 1);
        tx_data[0] = 8'hEE;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        chk("reset_blocks_accept", {31'd0, busy[0]}, 0);
        tx_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single byte, loopback
        send(0, 8'hA5, 8'hA5, 1, 0, a1);
        wait_idle(0);
        chk("t1_ss_low_first_cycle", {31'd0, ss_h[a1]}, 0);
        chk("t1_mosi_msb_first_cycle", {31'd0, mosi_h[a1]}, 1);
        mism = 0;
        rises = 0;
        for (int j = 0; j <= 66; j++) begin
            exp_sck = (j < 64) && (((j / 4) % 2) == 1);
            if (sck_h[a1 + j] !== exp_sck) mism++;
            if (j > 0 && sck_h[a1 + j] === 1'b1 && sck_h[a1 + j - 1] === 1'b0) rises++;
        end
        chk("t1_sck_shape_mismatches", mism, 0);
        chk("t1_sck_rising_edges", rises, 8);
        chk("t1_ss_high_during_frame", count_hi(0, a1, a1 + 64), 0);
        chk("t1_ss_high_after_rx_valid", {31'd0, ss_h[a1 + 65]}, 1);

        // Slave returns 0x3C while master sends 0xFF
        slave_en = 1'b1;
        slave_byte = 8'h3C;
        send(0, 8'hFF, 8'h3C, 1, 0, a1);
        wait_idle(0);
        chk("t2_mosi_ones", count_hi(1, a1, a1 + 64), 65);
        slave_en = 1'b0;

        // HOLD_SS back-to-back bytes
        hold_ss[0] = 1'b1;
        send(0, 8'h01, 8'h01, 1, 1, a1);
        tx_data[0] = 8'h80;
        send(0, 8'h80, 8'h80, 1, 0, a2);
        chk("t3_accept_spacing", a2 - a1, 65);
        repeat (72) @(negedge clk);
        chk("t3_hold_ss_low", {31'd0, ss[0]}, 0);
        chk("t3_hold_tx_ready", {31'd0, tx_ready[0]}, 1);
        chk("t3_hold_busy", {31'd0, busy[0]}, 1);
        chk("t3_ss_continuous_low", count_hi(0, a1, a2 + 64), 0);
        hold_ss[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_ss_released", {31'd0, ss[0]}, 1);
        chk("t3_gap_tx_ready", {31'd0, tx_ready[0]}, 0);
        wait_idle(0);

        // Two frames with TX_VALID held, SS gap
        send(0, 8'h11, 8'h11, 1, 1, a1);
        tx_data[0] = 8'h22;
        send(0, 8'h22, 8'h22, 1, 0, a2);
        chk("t4_accept_spacing", a2 - a1, 69);
        chk("t4_ss_high_cycles", count_hi(0, a1, a2), 4);
        chk("t4_tx_ready_in_gap", count_hi(2, a1 + 64, a1 + 67), 0);
        wait_idle(0);

        // Reset after third SCK rise, then 0x5A
        send(0, 8'hC3, 8'h00, 0, 0, a1);
        while (cyc < a1 + 20) @(negedge clk);
        chk("t5_sck_high_before_reset", {31'd0, sck[0]}, 1);
        rst = 1'b1;
        #1;
        chk("t5_reset_ss", {31'd0, ss[0]}, 1);
        chk("t5_reset_sck", {31'd0, sck[0]}, 0);
        chk("t5_reset_tx_ready", {31'd0, tx_ready[0]}, 1);
        tx_data[0] = 8'h5A;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        chk("t5_no_accept_in_reset", {31'd0, busy[0]}, 0);
        rst = 1'b0;
        rel = cyc;
        send(0, 8'h5A, 8'h5A, 1, 0, a2);
        chk("t5_accept_first_edge", a2, rel + 1);
        wait_idle(0);
        chk("t5_no_rx_valid_aborted", count_hi(3, a1, a2 + 63), 0);

        // CLK_DIV=2 instance
        send(1, 8'h96, 8'h96, 1, 0, a1);
        wait_idle(1);
        send(1, 8'h0F, 8'h0F, 1, 0, a1);
        wait_idle(1);

        for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_engine.md
SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in SBCLKi cycles; legal range 2..255.
REQ-002 SHALL have parameter SS_GAP, default 4: minimum SS-high time between frames, in SBCLKi cycles; legal range 1..255.
REQ-003 SHALL have port SBCLKi, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port TX_DATA, input, 8: byte to transmit, MSB first.
REQ-006 SHALL have port TX_VALID, input, 1: TX_DATA holds a valid byte.
REQ-007 SHALL have port TX_READY, output, 1: engine can accept a byte.
REQ-008 SHALL have port HOLD_SS, input, 1: keep SS low after the current byte.
REQ-009 SHALL have port RX_DATA, output, 8: byte received on MISO.
REQ-010 SHALL have port RX_VALID, output, 1: one-cycle pulse when RX_DATA is updated.
REQ-011 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-012 SHALL have port SCK, output, 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 SHALL have port SS, output, 1: active-low slave select.
REQ-014 SHALL have port MOSI, output, 1: master data out.
REQ-015 SHALL have port MISO, input, 1: slave data in; the instantiating level provides synchronization.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, HOLD and GAP.
REQ-017 SHALL drive TX_READY = 1 in IDLE and HOLD only, decoded directly from state.
REQ-018 SHALL accept a byte on a rising edge where RST=0, TX_VALID=1 and TX_READY=1; the byte is latched into the shift register and the FSM goes to SHIFT.
REQ-019 SHALL, in the cycle after acceptance, drive SS=0, SCK=0 and MOSI=TX_DATA[7].
REQ-020 SHALL, in SHIFT, toggle SCK every CLK_DIV cycles, giving 8 rising and 8 falling SCK edges per byte.
REQ-021 SHALL sample MISO into the LSB of the RX shift register on each SBCLKi edge where SCK is driven 0->1.
REQ-022 SHALL, on each SCK 1->0 transition except the last, present the next TX bit on MOSI.
REQ-023 SHALL return SCK to 0 on the 16th half-period; at that edge RX_DATA is loaded and RX_VALID=1 for exactly one cycle.
REQ-024 SHALL produce the RX_VALID cycle exactly 1+16*CLK_DIV cycles after the accepting edge (65 for CLK_DIV=4).
REQ-025 SHALL, at end of byte with HOLD_SS=1, enter HOLD with SS=0, SCK=0 and MOSI holding its last value.
REQ-026 SHALL, at end of byte with HOLD_SS=0, enter GAP with SS=1.
REQ-027 SHALL, in HOLD, start the next byte as in REQ-018/REQ-019 if TX_VALID=1, with SS remaining 0 and no glitch.
REQ-028 SHALL, in HOLD with TX_VALID=0 and HOLD_SS=0, enter GAP with SS=1.
REQ-029 SHALL give TX_VALID=1 priority over HOLD_SS=0 in HOLD: the byte is accepted and SS stays low.
REQ-030 SHALL hold GAP for exactly SS_GAP cycles with SS=1 and TX_READY=0, then enter IDLE.
REQ-031 SHALL hold RX_DATA stable between RX_VALID pulses.
REQ-032 SHALL ignore TX_DATA, TX_VALID and HOLD_SS changes during SHIFT, except HOLD_SS, which is sampled at the end-of-byte edge.

Reset
REQ-033 SHALL, while RST=1 and regardless of state, force: state=IDLE, SS=1, SCK=0, MOSI=0, RX_DATA=0x00, RX_VALID=0, BUSY=0, bit/phase counters=0.
REQ-034 SHALL make TX_READY read 1 during reset per REQ-017, with no acceptance possible while RST=1.
REQ-035 SHALL, when RST asserts mid-byte, abort the transfer immediately (SS=1 asynchronously), produce no RX_VALID, and allow a new byte on the first edge after release.

Verification
REQ-036 Bench SHALL cover single byte, CLK_DIV=4, loopback MISO=MOSI, TX 0xA5 -> SS low 1 cycle after accept; 8 SCK pulses of 4-high/4-low; RX_VALID 65 cycles after accept with RX_DATA=0xA5; SS=1 next cycle.
REQ-037 Bench SHALL cover slave model returning 0x3C while master sends 0xFF -> MOSI constant 1, RX_DATA=0x3C.
REQ-038 Bench SHALL cover HOLD_SS=1 with bytes 0x01,0x80 back-to-back -> SS continuously low across both bytes, two RX_VALID pulses 65 cycles apart (CLK_DIV=4, TX_VALID held), then SS=1 after HOLD_SS drops.
REQ-039 Bench SHALL cover HOLD_SS=0 with TX_VALID held high for 2 bytes -> SS high exactly SS_GAP=4 cycles between frames, TX_READY=0 throughout GAP.
REQ-040 Bench SHALL cover RST pulse after 3 SCK rising edges -> SS=1, SCK=0 same cycle, no RX_VALID, and the next byte 0x5A completes normally.
REQ-041 Bench SHALL cover CLK_DIV=2 boundary -> RX_VALID exactly 33 cycles after accept with correct data.
